// File: rtl/tx_framing_packer_if.sv
// Descriptor, payload-beat and output-word bundle between the TX MAC producer,
// the framing packer and the byte-striping stage.
interface tx_framing_packer_if #(
  parameter int SYMBOL_WIDTH  = 8,
  parameter int OUT_BYTES     = 32,
  parameter int PACKET_LENGTH = 11,
  parameter int SEQ_WIDTH     = 12
);
  logic                                 i_Desc_Valid;
  logic                                 o_Desc_Ready;
  logic                                 i_Type;
  logic [PACKET_LENGTH-1:0]             i_Length;
  logic [SEQ_WIDTH-1:0]                 i_Seq;
  logic                                 i_Data_Valid;
  logic                                 o_Data_Ready;
  logic [0:4*SYMBOL_WIDTH-1]            i_Data;
  logic                                 o_Valid;
  logic                                 i_Out_Ready;
  logic [0:OUT_BYTES*SYMBOL_WIDTH-1]    o_Data;
  logic [5:0]                           o_Byte_Count;
  logic                                 o_SOP;
  logic                                 o_EOP;
  logic                                 o_Err;
  logic                                 o_Busy;

  modport master (
    output i_Desc_Valid, i_Type, i_Length, i_Seq, i_Data_Valid, i_Data, i_Out_Ready,
    input  o_Desc_Ready, o_Data_Ready, o_Valid, o_Data, o_Byte_Count, o_SOP, o_EOP,
           o_Err, o_Busy
  );

  modport slave (
    input  i_Desc_Valid, i_Type, i_Length, i_Seq, i_Data_Valid, i_Data, i_Out_Ready,
    output o_Desc_Ready, o_Data_Ready, o_Valid, o_Data, o_Byte_Count, o_SOP, o_EOP,
           o_Err, o_Busy
  );
endinterface

// File: rtl/tx_framing_packer.sv
// TX framing packer: prepends the STP/SDP token to each packet and packs token plus
// DW payload into IDL-padded symbol words, every packet starting on a fresh word.
module tx_framing_packer #(
  parameter int                      SYMBOL_WIDTH  = 8,
  parameter int                      OUT_BYTES     = 32,
  parameter int                      PACKET_LENGTH = 11,
  parameter int                      SEQ_WIDTH     = 12,
  parameter logic [SYMBOL_WIDTH-1:0] IDL_SYMBOL    = 8'h00
) (
  input logic                CLK,
  input logic                RST,
  tx_framing_packer_if.slave bus
);
  localparam int                       WORD_BITS  = OUT_BYTES * SYMBOL_WIDTH;
  localparam logic [5:0]               FULL_PTR   = 6'(OUT_BYTES);
  localparam logic [PACKET_LENGTH-1:0] MAX_LEN    = PACKET_LENGTH'(1024);
  localparam logic [PACKET_LENGTH-1:0] DLLP_BEATS = PACKET_LENGTH'(2);

  typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_DRAIN} state_t;

  state_t                   state_reg, state_next;
  logic [0:WORD_BITS-1]     buf_reg;
  logic [5:0]               ptr_reg;
  logic [PACKET_LENGTH-1:0] rem_reg;
  logic                     dllp_reg;
  logic                     first_reg;
  logic                     pending_reg;
  logic [5:0]               count_hold_reg;
  logic                     eop_hold_reg;
  logic                     valid_reg;
  logic [0:WORD_BITS-1]     data_out_reg;
  logic [5:0]               count_out_reg;
  logic                     sop_reg;
  logic                     eop_reg;
  logic                     err_reg;

  logic                     desc_ready;
  logic                     data_ready;
  logic                     desc_fire;
  logic                     beat_fire;
  logic                     desc_bad;
  logic [5:0]               beat_bytes;
  logic [5:0]               ptr_adv;
  logic [PACKET_LENGTH-1:0] rem_dec;
  logic                     last_beat;
  logic                     word_done;
  logic                     out_free;
  logic [0:WORD_BITS-1]     token_word;
  logic [0:WORD_BITS-1]     word_next;

  assign desc_ready = (state_reg == S_IDLE) && !pending_reg;
  assign data_ready = (state_reg == S_PAYLOAD) && !pending_reg;
  assign desc_fire  = bus.i_Desc_Valid && desc_ready;
  assign beat_fire  = bus.i_Data_Valid && data_ready;
  assign desc_bad   = bus.i_Type && ((bus.i_Length == '0) || (bus.i_Length > MAX_LEN));

  // The closing DLLP beat carries only two bytes so a DLLP always totals 8.
  assign beat_bytes = (dllp_reg && (rem_reg == PACKET_LENGTH'(1))) ? 6'd2 : 6'd4;
  assign ptr_adv    = ptr_reg + beat_bytes;
  assign rem_dec    = rem_reg - PACKET_LENGTH'(1);
  assign last_beat  = (rem_dec == '0);
  assign word_done  = beat_fire && ((ptr_adv == FULL_PTR) || last_beat);
  assign out_free   = !valid_reg || bus.i_Out_Ready;

  always_comb begin
    token_word = {OUT_BYTES{IDL_SYMBOL}};
    if (bus.i_Type) begin
      token_word[0  +: 8] = {bus.i_Length[3:0], 4'hF};
      token_word[8  +: 8] = {1'b0, bus.i_Length[10:4]};
      token_word[16 +: 8] = {4'h0, bus.i_Seq[11:8]};
      token_word[24 +: 8] = bus.i_Seq[7:0];
    end else begin
      token_word[0 +: 8] = 8'hF0;
      token_word[8 +: 8] = 8'hAC;
    end
  end

  // Word as it stands after the current beat: held bytes, new beat bytes, IDL above.
  genvar gi;
  generate
    for (gi = 0; gi < OUT_BYTES; gi++) begin : g_byte
      logic [1:0]              lane;
      logic [SYMBOL_WIDTH-1:0] sym;
      assign lane = 2'(gi) - ptr_reg[1:0];
      always_comb begin
        sym = IDL_SYMBOL;
        if (6'(gi) < ptr_reg)
          sym = buf_reg[gi*SYMBOL_WIDTH +: SYMBOL_WIDTH];
        else if (6'(gi) < ptr_adv)
          sym = bus.i_Data[lane*SYMBOL_WIDTH +: SYMBOL_WIDTH];
      end
      assign word_next[gi*SYMBOL_WIDTH +: SYMBOL_WIDTH] = sym;
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (RST) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:    if (desc_fire && !desc_bad) state_next = S_PAYLOAD;
      S_PAYLOAD: if (word_done && last_beat) state_next = out_free ? S_IDLE : S_DRAIN;
      S_DRAIN:   if (pending_reg && out_free) state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      buf_reg        <= '0;
      ptr_reg        <= '0;
      rem_reg        <= '0;
      dllp_reg       <= 1'b0;
      first_reg      <= 1'b0;
      pending_reg    <= 1'b0;
      count_hold_reg <= '0;
      eop_hold_reg   <= 1'b0;
      valid_reg      <= 1'b0;
      data_out_reg   <= '0;
      count_out_reg  <= '0;
      sop_reg        <= 1'b0;
      eop_reg        <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      err_reg <= desc_fire && desc_bad;

      if (desc_fire && !desc_bad) begin
        buf_reg   <= token_word;
        ptr_reg   <= bus.i_Type ? 6'd4 : 6'd2;
        rem_reg   <= bus.i_Type ? bus.i_Length : DLLP_BEATS;
        dllp_reg  <= !bus.i_Type;
        first_reg <= 1'b1;
      end else if (beat_fire) begin
        buf_reg <= word_next;
        ptr_reg <= word_done ? 6'd0 : ptr_adv;
        rem_reg <= rem_dec;
        if (word_done && !out_free) begin
          pending_reg    <= 1'b1;
          count_hold_reg <= ptr_adv;
          eop_hold_reg   <= last_beat;
        end
      end

      // A completed word bypasses the pending stage when the output register is free,
      // which keeps word boundaries bubble-free at full rate.
      if (word_done && out_free) begin
        valid_reg     <= 1'b1;
        data_out_reg  <= word_next;
        count_out_reg <= ptr_adv;
        sop_reg       <= first_reg;
        eop_reg       <= last_beat;
        first_reg     <= 1'b0;
      end else if (pending_reg && out_free) begin
        valid_reg     <= 1'b1;
        data_out_reg  <= buf_reg;
        count_out_reg <= count_hold_reg;
        sop_reg       <= first_reg;
        eop_reg       <= eop_hold_reg;
        first_reg     <= 1'b0;
        pending_reg   <= 1'b0;
      end else if (bus.i_Out_Ready) begin
        valid_reg <= 1'b0;
      end
    end
  end

  assign bus.o_Desc_Ready = desc_ready;
  assign bus.o_Data_Ready = data_ready;
  assign bus.o_Valid      = valid_reg;
  assign bus.o_Data       = data_out_reg;
  assign bus.o_Byte_Count = count_out_reg;
  assign bus.o_SOP        = sop_reg;
  assign bus.o_EOP        = eop_reg;
  assign bus.o_Err        = err_reg;
  assign bus.o_Busy       = (state_reg != S_IDLE);
endmodule

// File: doc/tx_framing_packer.md
# tx_framing_packer

Transmit-side framing packer for the PCIe 5.0 MAC TX path, the counterpart of the RX packet filter and filtering buffer. It accepts one packet descriptor (type, length, sequence number) followed by DW-wide payload beats. It prepends the framing token (STP for TLPs, SDP for DLLPs) and packs token and payload into 32-byte symbol words for the TX byte-striping stage. Each packet starts at byte 0 of a fresh output word, and unused trailing bytes are padded with IDL.

## Interface
- SYMBOL_WIDTH, 8, bits per symbol
- OUT_BYTES, 32, symbols per output word; must be a multiple of 8
- PACKET_LENGTH, 11, width of the length field in DW; legal values 1..1024
- SEQ_WIDTH, 12, TLP sequence number width
- IDL_SYMBOL, 8'h00, pad symbol
- CLK  in  1  clock
- RST  in  1  reset; synchronous, active-high, one clock domain
- i_Desc_Valid / o_Desc_Ready  in/out  1  descriptor handshake
- i_Type  in  1  1 = TLP, 0 = DLLP
- i_Length  in  PACKET_LENGTH  TLP payload length in DW; ignored for DLLP
- i_Seq  in  SEQ_WIDTH  TLP sequence number
- i_Data_Valid / o_Data_Ready  in/out  1  payload beat handshake
- i_Data  in  [0:4*SYMBOL_WIDTH-1]  one DW; byte 0 sits in bits [0:7]
- o_Valid / i_Out_Ready  out/in  1  output word handshake
- o_Data  out  [0:OUT_BYTES*SYMBOL_WIDTH-1]  packed symbols; byte 0 first
- o_Byte_Count  out  6  number of valid bytes in o_Data (1..32)
- o_SOP, o_EOP  out  1  first and last word of a packet
- o_Err  out  1  one-cycle pulse when an illegal descriptor is dropped
- o_Busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, PAYLOAD, DRAIN.
- Internal registers: a 32-byte assembly buffer, a byte pointer ptr (0..32), a beat counter rem, a pending flag, and a first-word flag.

IDLE:
- o_Desc_Ready = !pending.
- On a descriptor handshake, TLP case with i_Length in 1..1024:
  - Write the STP token to bytes 0-3: byte0 = {i_Length[3:0], 4'hF}, byte1 = {1'b0, i_Length[10:4]}, byte2 = {4'h0, i_Seq[11:8]}, byte3 = i_Seq[7:0].
  - Set ptr = 4, rem = i_Length, set first-word flag, go to PAYLOAD.
- DLLP case:
  - Write the SDP token (F0, AC) to bytes 0-1.
  - Set ptr = 2, rem = 2, go to PAYLOAD.
- TLP with i_Length = 0 or > 1024:
  - Consume the descriptor, pulse o_Err, produce no output, stay in IDLE.

PAYLOAD:
- o_Data_Ready = !pending.
- Each accepted beat writes 4 bytes at ptr, then ptr += 4 and rem -= 1.
- DLLP final beat writes only i_Data bytes 0-1, and ptr += 2. A DLLP word is always 8 bytes: SDP plus 6 bytes.
- The word is complete when ptr reaches OUT_BYTES or rem reaches 0.
- On completion:
  - Set pending and latch count = ptr and the EOP flag (rem == 0).
  - Fill bytes at ptr and above with IDL_SYMBOL.
  - Reset ptr to 0.
  - If this was the last beat go to IDLE, else stay in PAYLOAD.

Transfer (any state):
- Condition: pending && (!o_Valid || i_Out_Ready).
- Action: the assembly buffer moves into the output register, o_Valid rises, and pending clears.
- o_SOP is set from the first-word flag, which then clears. o_EOP is set from the latched EOP flag.
- While pending is set, both o_Desc_Ready and o_Data_Ready are low. This is the only backpressure path.

DRAIN:
- Entered when RST is not asserted and a completed word is waiting on i_Out_Ready.
- Returns to IDLE when pending clears.
- An implementation may merge DRAIN into IDLE, provided o_Busy stays high while pending is set.

Arithmetic:
- ptr is 6 bits.
- rem is PACKET_LENGTH bits; a value of 1024 fits in 11 bits.
- o_Byte_Count = 4 + 4k for the first TLP word, 4k for later words, and 8 for DLLP.

## Timing
- Reset values: o_Valid = 0, o_Data = 0, o_Byte_Count = 0, o_SOP = 0, o_EOP = 0, o_Err = 0, o_Busy = 0, o_Desc_Ready = 1, o_Data_Ready = 0. FSM goes to IDLE, ptr = 0, pending = 0.
- RST asserted mid-packet abandons the packet; the next descriptor after reset starts clean.
- Descriptor accepted in cycle N: the first data beat is accepted no earlier than N+1.
- A word completed by a beat in cycle M has o_Valid = 1 in M+1 if the output register is free.
- o_Data, o_Byte_Count, o_SOP and o_EOP stay stable while o_Valid && !i_Out_Ready.
- o_Valid falls the cycle after acceptance unless another word transfers in that cycle.
- Full throughput: one beat per cycle with i_Out_Ready held high, and no bubble at word boundaries.
- A descriptor may be accepted in the same cycle as the final word's transfer.

## Test plan
- TLP, Length = 1, i_Seq = 12'h005, payload 11223344: one word with bytes 1F 00 00 05 11 22 33 44 then 24×00; o_Byte_Count = 8, o_SOP = o_EOP = 1; o_Valid appears 2 cycles after the descriptor.
- TLP, Length = 7: one full word with o_Byte_Count = 32, SOP and EOP set. Length = 8: two words, counts 32 then 4; the second has SOP = 0, EOP = 1.
- DLLP with beats AABBCCDD and EEFF9999: one word F0 AC AA BB CC DD EE FF then pad; count 8; the 9999 bytes are discarded.
- Length = 24 with i_Out_Ready low for 5 cycles after the first o_Valid: o_Data_Ready drops once the next word completes, no data is lost or duplicated, and outputs stay stable while stalled.
- Length = 0 and Length = 1025: a one-cycle o_Err pulse each, no o_Valid, and the FSM is back in IDLE with o_Desc_Ready = 1.
- RST pulsed after 3 beats of a Length = 16 TLP: all outputs return to reset values; a following Length = 1 TLP produces the exact word from scenario 1.
